serializer_dbuf: RTL and testbench
==================================

# serializer_dbuf

Parametrised, double-buffered parallel-to-serial shifter for the UART transmit path. It accepts a word through a valid/ready handshake into a one-entry holding buffer while the previous word is still shifting. It then emits one bit per enabled cycle, LSB- or MSB-first, and supplies the word's parity bit. The UART TX controller FSM drives `ser_en` and consumes `ser_data`, `ser_done` and `par_bit`, muxing them with the start and stop bits.

## Interface
- `DATA_WIDTH`, 8: word width in bits; legal range 2..16.
- `MSB_FIRST`, 0: 0 shifts bit 0 first; 1 shifts bit `DATA_WIDTH-1` first.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `p_data` input `DATA_WIDTH`: parallel word; sampled on accept.
- `data_valid` input 1: producer offers `p_data`.
- `data_ready` output 1: holding buffer empty; a word is accepted when `data_valid && data_ready`.
- `ser_en` input 1: controller requests or advances serial bits.
- `par_type` input 1: 0 selects even parity, 1 selects odd; sampled at SR load.
- `ser_data` output 1: current serial bit.
- `ser_done` output 1: high during the last data bit cycle.
- `par_bit` output 1: parity of the word currently in the shift register.
- `busy` output 1: shifting is in progress or the buffer is full.

## Operation
- Registers:
  - HB: holding buffer, `DATA_WIDTH` bits, plus flag `hb_full`.
  - SR: shift register, `DATA_WIDTH` bits.
  - `cnt`: bit counter, `$clog2(DATA_WIDTH)` bits.
  - `state`: IDLE or SHIFT.
  - `par_q`: registered parity.
- Accept: on `data_valid && !hb_full`, HB is loaded from `p_data` and `hb_full` is set. `data_ready = !hb_full`, decoded from registers only.
- IDLE:
  - `ser_data` = 0.
  - On `ser_en && hb_full`: SR is loaded from HB, `hb_full` is cleared, `cnt` is set to 0, `par_q` is set to `^HB ^ par_type`, and the state goes to SHIFT.
  - On `ser_en` with HB empty: the block stays in IDLE and the request is ignored; no error is flagged.
- SHIFT:
  - `ser_data` = SR[0] when `MSB_FIRST=0`, otherwise SR[`DATA_WIDTH-1`].
  - With `ser_en` = 1: SR shifts toward the output end with 0 filled in, and `cnt` increments.
  - With `ser_en` = 0: the block stalls. SR, `cnt` and `ser_data` hold.
- `ser_done = (state==SHIFT) && (cnt==DATA_WIDTH-1)`, decoded from registers.
  - If `ser_en` is high while `ser_done` is high, the next state is IDLE and `cnt` is set to 0.
  - If `ser_en` is low, `ser_done` stays high until `ser_en` returns.
- `par_bit = par_q`. It is stable from SR load until the next SR load, so the controller reads it after `ser_done`.
- `busy = (state==SHIFT) || hb_full`.
- Simultaneous events:
  - An accept and an SR load cannot coincide, because a load requires `hb_full`, which blocks `data_ready`.
  - An accept during SHIFT, including the final bit cycle, is legal.
  - There is no bypass from `p_data` to SR.
- The block never auto-restarts; every word needs a fresh `ser_en` edge from IDLE.

## Timing
- Reset values: `ser_data` 0, `ser_done` 0, `par_bit` 0, `data_ready` 1, `busy` 0. Internally `state`=IDLE, SR=0, HB=0, `cnt`=0.
- Reset asserted mid-word: the current bit is abandoned immediately and the pending HB word is discarded.
- Accept to first bit: one cycle after the accept edge, IDLE with `ser_en` high loads SR. The first bit then appears on `ser_data` in the cycle after that load edge.
- Frame length: exactly `DATA_WIDTH` enabled SHIFT cycles.
- `data_ready` rises the cycle after the SR-load edge, so a second word can be buffered while the first shifts.
- All outputs are decoded from registers; there is no combinational path from any input to any output.

## Structure
- Package `serializer_pkg` holds:
  - state encodings `ST_IDLE` = 1'b0 and `ST_SHIFT` = 1'b1;
  - parity constants `PAR_EVEN` = 0 and `PAR_ODD` = 1;
  - the counter width function.
- Sub-module `ser_hold_buf` (parametrised on `DATA_WIDTH`) provides the HB and `hb_full` handshake.
- The top level owns the FSM, SR, counter and parity logic.

## Test plan
- Reset, then release. Check `data_ready`=1, `busy`=0, `ser_data`=0 and `ser_done`=0. Hold `ser_en` with no data and check the block stays IDLE.
- LSB-first, 0xD2, `par_type`=0, `ser_en` held high. Required response:
  - `ser_data` = 0,1,0,0,1,0,1,1;
  - `ser_done` high on the 8th bit only;
  - `par_bit`=0;
  - the block returns to IDLE.
- `MSB_FIRST`=1, 0xD2, `par_type`=1. Check `ser_data` = 1,1,0,1,0,0,1,0 and `par_bit`=1. Also send 0x07 with `par_type`=0 and check `par_bit`=1.
- Stall: drop `ser_en` for 3 cycles after bit 3, then for 2 cycles during the `ser_done` cycle. Check bits and `ser_done` hold, and the total stays at 8 enabled cycles.
- Back-to-back: accept 0x55 during bit 2 of 0xAA. Required response:
  - `data_ready` falls;
  - the next IDLE+`ser_en` loads 0x55;
  - `data_ready` returns 1 the cycle after that load.
- Assert `rst` on bit 5 with HB full. All outputs go to their reset values at once. After release, a new 0x3C shifts correctly.

Source files
------------

// File: rtl/serializer_dbuf_pkg.sv
// Shared types and constants for the double-buffered UART transmit serializer.
package serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int dw);
        return (dw <= 2) ? 1 : $clog2(dw);
    endfunction

endpackage

// File: rtl/serializer_dbuf_if.sv
// Word handshake plus serial/controller signals between the UART TX controller and the serializer.
interface serializer_dbuf_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  data_ready;
    logic                  ser_en;
    logic                  par_type;
    logic                  ser_data;
    logic                  ser_done;
    logic                  par_bit;
    logic                  busy;

    modport master (
        output p_data, data_valid, ser_en, par_type,
        input  data_ready, ser_data, ser_done, par_bit, busy
    );

    modport slave (
        input  p_data, data_valid, ser_en, par_type,
        output data_ready, ser_data, ser_done, par_bit, busy
    );
endinterface

// File: rtl/serializer_dbuf_hold_buf.sv
// One-entry holding buffer: captures a word when empty, released when the shift register loads.
module ser_hold_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_take,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full
);
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_full;

    // Take only happens while full and accept only while empty, so they never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_take) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;
endmodule

// File: rtl/serializer_dbuf.sv
// Double-buffered parallel-to-serial shifter with registered parity for the UART transmit path.
module serializer_dbuf
    import serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic            clk,
    input  logic            rst,
    serializer_dbuf_if.slave bus
);
    localparam int             CW   = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [CW-1:0]         r_cnt;
    logic                  r_par_q;
    logic [DATA_WIDTH-1:0] w_hb_data;
    logic                  w_hb_full;
    logic                  w_load;
    logic                  w_last;

    ser_hold_buf #(.DATA_WIDTH(DATA_WIDTH)) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .i_data  (bus.p_data),
        .i_valid (bus.data_valid),
        .i_take  (w_load),
        .o_data  (w_hb_data),
        .o_full  (w_hb_full)
    );

    assign w_load = (r_state == ST_IDLE) && bus.ser_en && w_hb_full;
    assign w_last = (r_state == ST_SHIFT) && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_load) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (bus.ser_en && w_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift toward the output end with zero fill; a low ser_en freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_par_q <= 1'b0;
        end else if (w_load) begin
            r_sr    <= w_hb_data;
            r_cnt   <= '0;
            r_par_q <= (^w_hb_data) ^ (bus.par_type == PAR_ODD);
        end else if ((r_state == ST_SHIFT) && bus.ser_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (MSB_FIRST != 0) r_sr <= {r_sr[DATA_WIDTH-2:0], 1'b0};
            else                r_sr <= {1'b0, r_sr[DATA_WIDTH-1:1]};
        end
    end

    always_comb begin
        bus.ser_data = 1'b0;
        if (r_state == ST_SHIFT)
            bus.ser_data = (MSB_FIRST != 0) ? r_sr[DATA_WIDTH-1] : r_sr[0];
        bus.ser_done   = w_last;
        bus.par_bit    = r_par_q;
        bus.busy       = (r_state == ST_SHIFT) || w_hb_full;
        bus.data_ready = !w_hb_full;
    end
endmodule

// File: tb/tb_serializer_dbuf.sv
// Drives an LSB-first and an MSB-first serializer in lockstep and checks them against a word-level model.
module tb_serializer_dbuf;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   hb_pend  = 0;

    serializer_dbuf_if #(.DATA_WIDTH(8)) if_lsb ();
    serializer_dbuf_if #(.DATA_WIDTH(8)) if_msb ();

    serializer_dbuf #(.DATA_WIDTH(8), .MSB_FIRST(0)) u_lsb (.clk(clk), .rst(rst), .bus(if_lsb));
    serializer_dbuf #(.DATA_WIDTH(8), .MSB_FIRST(1)) u_msb (.clk(clk), .rst(rst), .bus(if_msb));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic en, input logic pt);
        if_lsb.data_valid = v;  if_msb.data_valid = v;
        if_lsb.p_data     = d;  if_msb.p_data     = d;
        if_lsb.ser_en     = en; if_msb.ser_en     = en;
        if_lsb.par_type   = pt; if_msb.par_type   = pt;
    endtask

    task automatic set_en(input logic en);
        if_lsb.ser_en = en;
        if_msb.ser_en = en;
    endtask

    task automatic set_valid(input logic v, input logic [7:0] d);
        if_lsb.data_valid = v; if_msb.data_valid = v;
        if_lsb.p_data     = d; if_msb.p_data     = d;
    endtask

    task automatic chk_idle(input string tag, input logic rdy, input logic par);
        chk({tag, "_lsb_data"},  if_lsb.ser_data,   1'b0);
        chk({tag, "_msb_data"},  if_msb.ser_data,   1'b0);
        chk({tag, "_lsb_done"},  if_lsb.ser_done,   1'b0);
        chk({tag, "_msb_done"},  if_msb.ser_done,   1'b0);
        chk({tag, "_lsb_ready"}, if_lsb.data_ready, rdy);
        chk({tag, "_msb_ready"}, if_msb.data_ready, rdy);
        chk({tag, "_lsb_busy"},  if_lsb.busy,       !rdy);
        chk({tag, "_msb_busy"},  if_msb.busy,       !rdy);
        chk({tag, "_lsb_par"},   if_lsb.par_bit,    par);
        chk({tag, "_msb_par"},   if_msb.par_bit,    par);
    endtask

    task automatic chk_bit(input logic [7:0] w, input logic par, input int i, input logic rdy);
        string t;
        t = $sformatf("w%02h_b%0d", w, i);
        chk({t, "_lsb_data"},  if_lsb.ser_data,   w[i]);
        chk({t, "_msb_data"},  if_msb.ser_data,   w[7-i]);
        chk({t, "_lsb_done"},  if_lsb.ser_done,   i == 7);
        chk({t, "_msb_done"},  if_msb.ser_done,   i == 7);
        chk({t, "_lsb_par"},   if_lsb.par_bit,    par);
        chk({t, "_msb_par"},   if_msb.par_bit,    par);
        chk({t, "_lsb_busy"},  if_lsb.busy,       1'b1);
        chk({t, "_lsb_ready"}, if_lsb.data_ready, rdy);
        chk({t, "_msb_ready"}, if_msb.data_ready, rdy);
    endtask

    // One word through the pipe; optional stalls, a mid-frame accept, or a reset abort.
    task automatic frame(input logic [7:0] w, input logic p, input bit pre,
                         input int sa, input int sl, input int sb, input int sbl,
                         input int acc_at, input logic [7:0] nw, input int abort_at);
        logic par;
        logic rdy;
        par = logic'($countones(w) % 2) ^ p;
        if (!pre) begin
            drive(1'b1, w, 1'b0, p);
            tick();
            set_valid(1'b0, 8'h00);
            chk_idle("accepted", 1'b0, if_lsb.par_bit);
        end
        set_en(1'b1);
        if_lsb.par_type = p; if_msb.par_type = p;
        tick();
        hb_pend = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk_idle("abort", 1'b1, 1'b0);
                drive(1'b0, 8'h00, 1'b0, 1'b0);
                tick();
                rst = 1'b0;
                hb_pend = 0;
                return;
            end
            rdy = !hb_pend;
            chk_bit(w, par, i, rdy);
            if (i == sa || i == sb) begin
                for (int s = 0; s < ((i == sa) ? sl : sbl); s++) begin
                    set_en(1'b0);
                    tick();
                    chk_bit(w, par, i, rdy);
                end
                set_en(1'b1);
            end
            if (i == acc_at) set_valid(1'b1, nw);
            tick();
            if (i == acc_at) begin
                set_valid(1'b0, 8'h00);
                hb_pend = 1;
            end
        end
        chk_idle($sformatf("w%02h_end", w), !hb_pend, par);
        set_en(1'b0);
    endtask

    initial begin
        logic [7:0] w, nw;
        logic       p;
        bit         pre;
        int         sa, sb, acc;

        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_idle("reset", 1'b1, 1'b0);

        set_en(1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_idle($sformatf("idle_en%0d", k), 1'b1, 1'b0);
        end
        set_en(1'b0);

        frame(8'hD2, 1'b0, 0, -1, 0, -1, 0, -1, 8'h00, -1);
        frame(8'hD2, 1'b1, 0, -1, 0, -1, 0, -1, 8'h00, -1);
        frame(8'h07, 1'b0, 0, -1, 0, -1, 0, -1, 8'h00, -1);
        frame(8'hB6, 1'b0, 0,  3, 3,  7, 2, -1, 8'h00, -1);
        frame(8'hAA, 1'b0, 0, -1, 0, -1, 0,  2, 8'h55, -1);
        frame(8'h55, 1'b1, 1, -1, 0, -1, 0, -1, 8'h00, -1);
        frame(8'h9E, 1'b0, 0, -1, 0, -1, 0,  1, 8'h81,  5);
        tick();
        chk_idle("post_reset", 1'b1, 1'b0);
        frame(8'h3C, 1'b0, 0, -1, 0, -1, 0, -1, 8'h00, -1);

        pre = 0;
        w   = 8'($urandom_range(0, 255));
        for (int n = 0; n < 40; n++) begin
            p   = 1'($urandom_range(0, 1));
            sa  = $urandom_range(0, 11);
            sb  = $urandom_range(0, 11);
            acc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            nw  = 8'($urandom_range(0, 255));
            frame(w, p, pre, sa, $urandom_range(1, 3), sb, $urandom_range(1, 2), acc, nw, -1);
            pre = (acc >= 0);
            w   = pre ? nw : 8'($urandom_range(0, 255));
            if (!pre && $urandom_range(0, 1) == 1) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
